// File: rtl/multi_timer_pkg.sv
// Shared constants for multi_timer: register offsets, CTRL bit positions, bus modes.
// Capture support is selected with MULTI_TIMER_CAPTURE_EN.
package multi_timer_pkg;

    localparam logic [4:0]  GCTRL_OFS    = 5'h00;
    localparam logic [4:0]  PSC_TH_OFS   = 5'h04;
    localparam logic [4:0]  IRQ_STAT_OFS = 5'h08;
    localparam logic [4:0]  IRQ_MASK_OFS = 5'h0C;

    localparam logic [31:0] CH_BASE      = 32'h20;
    localparam logic [31:0] CH_STRIDE    = 32'h20;

    localparam logic [4:0]  CH_CTRL_OFS  = 5'h00;
    localparam logic [4:0]  CH_TOP_OFS   = 5'h04;
    localparam logic [4:0]  CH_CMP_OFS   = 5'h08;
    localparam logic [4:0]  CH_CNT_OFS   = 5'h0C;
    localparam logic [4:0]  CH_CAP_OFS   = 5'h10;

    localparam int unsigned CTRL_W            = 4;
    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_CMP_EN_BIT   = 1;
    localparam int unsigned CTRL_ONE_SHOT_BIT = 2;
    localparam int unsigned CTRL_INVERT_BIT   = 3;

    typedef enum logic [1:0] {
        BUS_IDLE     = 2'b00,
        BUS_READ     = 2'b01,
        BUS_WRITE    = 2'b10,
        BUS_IDLE_ALT = 2'b11
    } bus_mode_e;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: counter, TOP/CMP/CTRL registers, compare output and the
// optional capture path (built only with MULTI_TIMER_CAPTURE_EN).
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              gctrl_en,
    input  logic              wr_ctrl,
    input  logic              wr_top,
    input  logic              wr_cmp,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              capture_in,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  top_val,
    output logic [CNT_W-1:0]  cmp_val,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [CNT_W-1:0]  cap_val,
    output logic              wrap,
    output logic              cap_evt,
    output logic              cmp_out
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cmp_q, cmp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmp_out_q, cmp_out_d;

    always_comb begin
        ctrl_d    = ctrl_q;
        top_d     = top_q;
        cmp_d     = cmp_q;
        cnt_d     = cnt_q;
        wrap      = 1'b0;
        if (wr_ctrl) ctrl_d = wr_data[CTRL_W-1:0];
        if (wr_top)  top_d  = wr_data;
        if (wr_cmp)  cmp_d  = wr_data;
        // Any configuration write restarts the count and swallows a coincident tick.
        if (wr_ctrl || wr_top || wr_cmp) begin
            cnt_d = '0;
        end else if (tick && gctrl_en && ctrl_q[CTRL_EN_BIT]) begin
            if (cnt_q >= top_q) begin
                cnt_d = '0;
                wrap  = 1'b1;
                if (ctrl_q[CTRL_ONE_SHOT_BIT]) ctrl_d[CTRL_EN_BIT] = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        cmp_out_d = (ctrl_q[CTRL_EN_BIT] & ctrl_q[CTRL_CMP_EN_BIT] & (cnt_q < cmp_q))
                    ^ ctrl_q[CTRL_INVERT_BIT];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            top_q     <= '0;
            cmp_q     <= '0;
            cnt_q     <= '0;
            cmp_out_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            top_q     <= top_d;
            cmp_q     <= cmp_d;
            cnt_q     <= cnt_d;
            cmp_out_q <= cmp_out_d;
        end
    end

`ifdef MULTI_TIMER_CAPTURE_EN
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cap_q, cap_d;

    // Rising edge seen after two synchroniser stages; captures the live count.
    assign cap_evt = gctrl_en & sync2_q & ~prev_q;

    always_comb begin
        cap_d = cap_q;
        if (cap_evt) cap_d = cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cap_q   <= '0;
        end else begin
            sync1_q <= capture_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cap_q   <= cap_d;
        end
    end

    assign cap_val = cap_q;
`else
    logic unused_capture_in;
    assign unused_capture_in = capture_in;
    assign cap_evt           = 1'b0;
    assign cap_val           = '0;
`endif

    assign ctrl    = ctrl_q;
    assign top_val = top_q;
    assign cmp_val = cmp_q;
    assign cnt_val = cnt_q;
    assign cmp_out = cmp_out_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel bus timer: shared prescaler, global registers, address decode and
// combined active-low IRQ. Optional capture inputs via MULTI_TIMER_CAPTURE_EN.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4100,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [31:0]       data_bus_data,
    input  logic [31:0]       data_bus_addr,
    input  logic [1:0]        data_bus_mode,
    input  logic [NUM_CH-1:0] capture_in,
    output logic              timer_irq_n,
    output logic [NUM_CH-1:0] cmp_out
);

`ifdef MULTI_TIMER_CAPTURE_EN
    localparam int unsigned IRQ_W = 2 * NUM_CH;
`else
    localparam int unsigned IRQ_W = NUM_CH;
`endif
    localparam logic [31:0] WIN_SIZE = CH_BASE + CH_STRIDE * 32'(NUM_CH);

    bus_mode_e   bus_mode;
    logic [31:0] off;
    logic        in_window, glb_sel, rd_en, wr_en;
    logic [31:0] rd_data;
    logic [31:0] wr_data;

    assign bus_mode  = bus_mode_e'(data_bus_mode);
    assign off       = data_bus_addr - BASE_ADDR;
    assign in_window = (data_bus_addr >= BASE_ADDR) && (off < WIN_SIZE);
    assign glb_sel   = (off[31:5] == 27'd0);
    assign rd_en     = in_window && (bus_mode == BUS_READ);
    assign wr_en     = in_window && (bus_mode == BUS_WRITE);
    assign wr_data   = data_bus_data;

    assign data_bus_data = rd_en ? rd_data : 'z;

    logic             gctrl_q, gctrl_d;
    logic [31:0]      psc_th_q, psc_th_d;
    logic [31:0]      psc_q, psc_d;
    logic [IRQ_W-1:0] irq_stat_q, irq_stat_d;
    logic [IRQ_W-1:0] irq_mask_q, irq_mask_d;
    logic             irq_n_q, irq_n_d;
    logic             tick;
    logic             wr_gctrl, wr_psc_th, wr_irq_stat, wr_irq_mask;

    logic [NUM_CH-1:0]           ch_wrap;
    logic [NUM_CH-1:0]           ch_cap_evt;
    logic [NUM_CH-1:0][31:0]     ch_rdata;
    logic [IRQ_W-1:0]            irq_set;

    assign wr_gctrl    = wr_en && glb_sel && (off[4:0] == GCTRL_OFS);
    assign wr_psc_th   = wr_en && glb_sel && (off[4:0] == PSC_TH_OFS);
    assign wr_irq_stat = wr_en && glb_sel && (off[4:0] == IRQ_STAT_OFS);
    assign wr_irq_mask = wr_en && glb_sel && (off[4:0] == IRQ_MASK_OFS);

`ifdef MULTI_TIMER_CAPTURE_EN
    assign irq_set = {ch_cap_evt, ch_wrap};
`else
    logic unused_cap_evt;
    assign unused_cap_evt = |ch_cap_evt;
    assign irq_set        = ch_wrap;
`endif

    always_comb begin
        gctrl_d    = gctrl_q;
        psc_th_d   = psc_th_q;
        irq_mask_d = irq_mask_q;
        if (wr_gctrl)    gctrl_d    = wr_data[0];
        if (wr_psc_th)   psc_th_d   = wr_data;
        if (wr_irq_mask) irq_mask_d = wr_data[IRQ_W-1:0];

        tick = gctrl_q && (psc_q == psc_th_q);
        if (wr_gctrl || wr_psc_th || !gctrl_q || tick) psc_d = '0;
        else                                           psc_d = psc_q + 32'd1;

        // Set is OR-ed in after the W1C clear so a coincident event is never lost.
        irq_stat_d = (irq_stat_q & ~(wr_irq_stat ? wr_data[IRQ_W-1:0] : '0)) | irq_set;
        irq_n_d    = ~|(irq_stat_q & irq_mask_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gctrl_q    <= 1'b0;
            psc_th_q   <= '0;
            psc_q      <= '0;
            irq_stat_q <= '0;
            irq_mask_q <= '0;
            irq_n_q    <= 1'b1;
        end else begin
            gctrl_q    <= gctrl_d;
            psc_th_q   <= psc_th_d;
            psc_q      <= psc_d;
            irq_stat_q <= irq_stat_d;
            irq_mask_q <= irq_mask_d;
            irq_n_q    <= irq_n_d;
        end
    end

    assign timer_irq_n = irq_n_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Channel i sits at 0x20*(i+1), so the offset's upper bits are i+1.
        localparam logic [26:0] CH_IDX = 27'(gi + 1);
        logic              ch_sel;
        logic [CTRL_W-1:0] ch_ctrl;
        logic [CNT_W-1:0]  ch_top, ch_cmp, ch_cnt, ch_cap;
        logic [31:0]       rd_ch;

        assign ch_sel = (off[31:5] == CH_IDX);

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .gctrl_en   (gctrl_q),
            .wr_ctrl    (wr_en && ch_sel && (off[4:0] == CH_CTRL_OFS)),
            .wr_top     (wr_en && ch_sel && (off[4:0] == CH_TOP_OFS)),
            .wr_cmp     (wr_en && ch_sel && (off[4:0] == CH_CMP_OFS)),
            .wr_data    (wr_data[CNT_W-1:0]),
            .capture_in (capture_in[gi]),
            .ctrl       (ch_ctrl),
            .top_val    (ch_top),
            .cmp_val    (ch_cmp),
            .cnt_val    (ch_cnt),
            .cap_val    (ch_cap),
            .wrap       (ch_wrap[gi]),
            .cap_evt    (ch_cap_evt[gi]),
            .cmp_out    (cmp_out[gi])
        );

        always_comb begin
            rd_ch = '0;
            if (ch_sel) begin
                case (off[4:0])
                    CH_CTRL_OFS: rd_ch = 32'(ch_ctrl);
                    CH_TOP_OFS:  rd_ch = 32'(ch_top);
                    CH_CMP_OFS:  rd_ch = 32'(ch_cmp);
                    CH_CNT_OFS:  rd_ch = 32'(ch_cnt);
                    CH_CAP_OFS:  rd_ch = 32'(ch_cap);
                    default:     rd_ch = '0;
                endcase
            end
        end

        assign ch_rdata[gi] = rd_ch;
    end

    always_comb begin
        rd_data = '0;
        if (glb_sel) begin
            case (off[4:0])
                GCTRL_OFS:    rd_data = {31'd0, gctrl_q};
                PSC_TH_OFS:   rd_data = psc_th_q;
                IRQ_STAT_OFS: rd_data = 32'(irq_stat_q);
                IRQ_MASK_OFS: rd_data = 32'(irq_mask_q);
                default:      rd_data = '0;
            endcase
        end else begin
            for (int i = 0; i < NUM_CH; i++) rd_data = rd_data | ch_rdata[i];
        end
    end

endmodule
